// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 line-buffer filter and its line feeder.
package filter_pkg;

  localparam int unsigned PIX_W                = 16;
  localparam int unsigned CURSOR_W             = 10;
  localparam int unsigned DEFAULT_BLOCK_LENGTH = 720;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StGap   = 3'd2;
  localparam logic [2:0] StRdSet = 3'd3;
  localparam logic [2:0] StRdOut = 3'd4;

endpackage

// File: rtl/filter_line_feeder.sv
// Writes raw lines into the 3x3 filter, then walks the cursor back across the line and
// forwards each settled filtered pixel downstream on a valid/ready port.
module filter_line_feeder
  import filter_pkg::*;
#(
  parameter int unsigned BLOCK_LENGTH = DEFAULT_BLOCK_LENGTH,
  parameter int unsigned PRIME_LINES  = 2,
  parameter int unsigned RD_SETTLE    = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PIX_W-1:0]    s_data,
  input  logic                s_valid,
  input  logic                s_sof,
  output logic                s_ready,
  output logic [PIX_W-1:0]    f_d_in,
  output logic                f_wren,
  output logic [CURSOR_W-1:0] f_cursor,
  input  logic [PIX_W-1:0]    f_d_out,
  input  logic                f_d_rdy,
  output logic [PIX_W-1:0]    m_data,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic                sof_err
);

  localparam int unsigned SettleW = (RD_SETTLE > 3) ? $clog2(RD_SETTLE + 1) : 2;
  localparam int unsigned LcW     = $clog2(PRIME_LINES + 2);

  localparam logic [CURSOR_W-1:0] LastIdx    = CURSOR_W'(BLOCK_LENGTH - 1);
  localparam logic [SettleW-1:0]  SettleInit = SettleW'(RD_SETTLE);
  localparam logic [LcW-1:0]      LcMax      = LcW'(PRIME_LINES + 1);
  localparam logic [LcW-1:0]      LcPrime    = LcW'(PRIME_LINES);

  logic [2:0]          state_q, state_d;
  logic [CURSOR_W-1:0] wr_idx_q, wr_idx_d;
  logic [CURSOR_W-1:0] rd_idx_q, rd_idx_d;
  logic [LcW-1:0]      line_cnt_q, line_cnt_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic                s_ready_q, s_ready_d;
  logic                f_wren_q, f_wren_d;
  logic [CURSOR_W-1:0] f_cursor_q, f_cursor_d;
  logic [PIX_W-1:0]    f_d_in_q, f_d_in_d;
  logic [PIX_W-1:0]    m_data_q, m_data_d;
  logic                m_valid_q, m_valid_d;
  logic                m_last_q, m_last_d;
  logic                sof_err_q, sof_err_d;
  logic [LcW-1:0]      lc_inc;
  logic                accept;

  assign accept = (state_q == StWrite) && s_valid && s_ready_q;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    line_cnt_d = line_cnt_q;
    settle_d   = settle_q;
    s_ready_d  = s_ready_q;
    f_wren_d   = f_wren_q;
    f_cursor_d = f_cursor_q;
    f_d_in_d   = f_d_in_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    sof_err_d  = 1'b0;
    lc_inc     = (line_cnt_q == LcMax) ? LcMax : line_cnt_q + LcW'(1);

    case (state_q)
      StIdle: begin
        if (s_valid) begin
          state_d    = StWrite;
          wr_idx_d   = '0;
          s_ready_d  = 1'b1;
          f_wren_d   = 1'b1;
          f_cursor_d = '0;
        end
      end
      StWrite: begin
        // f_wren stays high across stalls; the filter rotates rows on its rising edge.
        if (accept) begin
          f_d_in_d   = s_data;
          f_cursor_d = wr_idx_q;
          if (s_sof && (wr_idx_q == '0)) line_cnt_d = '0;
          if (s_sof && (wr_idx_q != '0)) sof_err_d = 1'b1;
          if (wr_idx_q == LastIdx) begin
            state_d   = StGap;
            s_ready_d = 1'b0;
            f_wren_d  = 1'b0;
          end else begin
            wr_idx_d = wr_idx_q + CURSOR_W'(1);
          end
        end
      end
      StGap: begin
        line_cnt_d = lc_inc;
        if (lc_inc > LcPrime) begin
          state_d    = StRdSet;
          rd_idx_d   = '0;
          f_cursor_d = '0;
          settle_d   = SettleInit;
        end else begin
          state_d = StIdle;
        end
      end
      StRdSet: begin
        // f_d_rdy is ignored until the cursor has had time to settle.
        if (settle_q != '0) begin
          settle_d = settle_q - SettleW'(1);
        end else if (f_d_rdy) begin
          m_data_d  = f_d_out;
          m_valid_d = 1'b1;
          m_last_d  = (rd_idx_q == LastIdx);
          state_d   = StRdOut;
        end
      end
      StRdOut: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (m_last_q) begin
            state_d = StIdle;
          end else begin
            rd_idx_d   = rd_idx_q + CURSOR_W'(1);
            f_cursor_d = rd_idx_q + CURSOR_W'(1);
            settle_d   = SettleInit;
            state_d    = StRdSet;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      line_cnt_q <= '0;
      settle_q   <= '0;
      s_ready_q  <= 1'b0;
      f_wren_q   <= 1'b0;
      f_cursor_q <= '0;
      f_d_in_q   <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      sof_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      line_cnt_q <= line_cnt_d;
      settle_q   <= settle_d;
      s_ready_q  <= s_ready_d;
      f_wren_q   <= f_wren_d;
      f_cursor_q <= f_cursor_d;
      f_d_in_q   <= f_d_in_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      sof_err_q  <= sof_err_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign f_wren   = f_wren_q;
  assign f_cursor = f_cursor_q;
  assign f_d_in   = f_d_in_q;
  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign sof_err  = sof_err_q;

endmodule
